reg_checkpoint_ctrl: RTL and testbench
======================================

# reg_checkpoint_ctrl

Register-file checkpoint controller for speculative branch recovery. Captures a full copy of the architectural register file into one of `DEPTH` in-order slots when decode issues a predicted branch. Retires the oldest slot when that branch resolves correct; on a mispredict it drives `reg_file`'s snapshot-restore port and stalls the front end. Sits beside `reg_file`, fed by decode/branch-resolve and write-back.

## Interface
- `DEPTH`, 4, number of checkpoint slots; power of two, ≥2
- `IDW`, $clog2(DEPTH), slot index width
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `ckpt_req`  in  1  decode requests a checkpoint for a predicted branch
- `ckpt_ack`  out  1  request accepted this cycle (combinational)
- `ckpt_id`  out  IDW  slot index allocated (valid with `ckpt_ack`)
- `resolve_valid`  in  1  oldest outstanding branch resolved this cycle
- `resolve_mispredict`  in  1  qualifies `resolve_valid`: 1 = mispredict
- `resolve_err`  out  1  sticky: resolve received with zero outstanding slots
- `i_wb`  `write_back_ifc.in`  —  write-back port (`uses_rw`, `rw_addr`, `rw_data`)
- `regs_in`  in  32×`DATA_WIDTH`  current register contents from `reg_file.regs_out`
- `recover_snapshot`  out  1  restore strobe to `reg_file`
- `regs_snapshot`  out  32×`DATA_WIDTH`  restore image to `reg_file`
- `stall`  out  1  front-end stall
- `ckpt_full`  out  1  all slots occupied
- `ckpt_count`  out  IDW+1  occupied slots

## Operation
- Slots form a circular FIFO: `head` = oldest, `tail` = next free, `count` 0..DEPTH.
- FSM states: IDLE, RESTORE.
- IDLE accept: `ckpt_ack = ckpt_req && state==IDLE && !(resolve_valid && resolve_mispredict) && (count<DEPTH || (resolve_valid && !resolve_mispredict))`.
  - Full + same-cycle correct resolve → request accepted.
  - `ckpt_id = tail`.
- Capture: slot[tail] ← `regs_in` with that cycle's write-back merged (if `i_wb.uses_rw` and `rw_addr`≠0, entry `rw_addr` ← `rw_data`). The slot therefore equals the register file after the clock edge.
- On accept: `tail++` (mod DEPTH).
- Correct resolve with count>0: `head++` (mod DEPTH). Accept and correct resolve in the same cycle → count unchanged.
- Mispredict with count>0:
  - latch slot[head] into the restore register;
  - go to RESTORE;
  - head = tail = 0, count = 0 (all younger checkpoints discarded);
  - pending request dropped.
- Any resolve with count==0: ignored, `resolve_err` set. It clears only on reset.
- RESTORE (exactly one cycle):
  - `recover_snapshot=1`, `regs_snapshot`=latched image, `stall=1`;
  - `ckpt_ack=0`, resolves ignored;
  - next state IDLE.
- `resolve_mispredict` is ignored when `resolve_valid`=0.

## Timing
- Capture latency: slot written at the edge where `ckpt_ack`=1.
- Restore latency: mispredict at edge N → `recover_snapshot` high for cycle N+1 only. `reg_file` holds the restored image from cycle N+1 onward.
- `stall` high in every RESTORE cycle and also combinationally in the mispredict cycle.
- `ckpt_full` and `ckpt_count` are registered and reflect state after the last edge.
- Reset values: state IDLE, head/tail/count 0, `resolve_err` 0, `recover_snapshot` 0, `regs_snapshot` all 0, `stall` 0, `ckpt_full` 0. Slot contents are not reset.
- Reset asserted during RESTORE aborts the strobe immediately.
- Write-back to r0 is never merged into a snapshot.

## Structure
- Shared package `ckpt_pkg`: `ckpt_state_t` enum {IDLE, RESTORE}, default `CKPT_DEPTH`. `DATA_WIDTH` comes from `mips_core.svh`.
- Sub-module `reg_ckpt_store`: DEPTH×32×`DATA_WIDTH` slot array with one write port (merged capture) and one read port at `head`, no reset.
- Controller holds the pointers, FSM and restore register.

## Test plan
- Capture then correct resolve:
  - r5=0x11, req → ack, id 0, count 1;
  - resolve correct → count 0, no strobe.
- Merge:
  - req in the same cycle as WB r7←0xAB, then WB r7←0xCD;
  - mispredict → strobe one cycle later, image r7=0xAB.
- Fill/wrap:
  - DEPTH reqs → `ckpt_full`=1; next req alone → ack 0;
  - req plus correct resolve in one cycle → ack 1, id wraps to 0, count stays DEPTH.
- Flush:
  - three checkpoints, mispredict on oldest → image of slot 0, count 0;
  - req in RESTORE cycle → ack 0, `stall`=1.
- Error: resolve with count 0 → `resolve_err`=1 and stays set; pointers unchanged.
- Reset mid-RESTORE: `rst_n` low → `recover_snapshot`, `stall`, count all 0 immediately.

Source files
------------

// File: rtl/ckpt_pkg.sv
// Shared types and defaults for the register-file checkpoint controller.
package ckpt_pkg;
  typedef enum logic {IDLE = 1'b0, RESTORE = 1'b1} ckpt_state_t;
  localparam int CKPT_DEPTH = 4;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
endpackage

// File: rtl/write_back_ifc.sv
// Write-back bus from the pipeline into the register file and its observers.
`include "mips_core.svh"
interface write_back_ifc;
  logic                   uses_rw;
  logic [4:0]             rw_addr;
  logic [`DATA_WIDTH-1:0] rw_data;
  modport in  (input  uses_rw, rw_addr, rw_data);
  modport out (output uses_rw, rw_addr, rw_data);
endinterface

// File: rtl/mips_core.svh
// Core-wide width definitions shared by the register file and its neighbours.
`ifndef MIPS_CORE_SVH
`define MIPS_CORE_SVH
`define DATA_WIDTH 32
`endif

// File: rtl/reg_ckpt_store.sv
// Checkpoint slot array: one merged-capture write port, one read port at the oldest slot.
`include "mips_core.svh"
module reg_ckpt_store
  import ckpt_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int DW    = `DATA_WIDTH,
  parameter int IDW   = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [IDW-1:0]        wr_idx,
  input  logic [DW-1:0]         regs_in [NUM_REGS],
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DW-1:0]         wb_data,
  input  logic [IDW-1:0]        rd_idx,
  output logic [DW-1:0]         rd_regs [NUM_REGS]
);
  logic [DW-1:0] slot_mem [DEPTH][NUM_REGS];
  logic [DW-1:0] wr_row   [NUM_REGS];

  // Same-cycle write-back is folded in so a slot matches the post-edge register file.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_row
    if (gi == 0) begin : g_r0
      assign wr_row[gi] = regs_in[gi];
    end else begin : g_rn
      assign wr_row[gi] = (wb_en && wb_addr == REG_ADDR_W'(gi)) ? wb_data : regs_in[gi];
    end
    assign rd_regs[gi] = slot_mem[rd_idx][gi];
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        slot_mem[wr_idx][i] <= wr_row[i];
      end
    end
  end
endmodule

// File: rtl/reg_checkpoint_ctrl.sv
// Checkpoint controller: in-order slot FIFO, branch resolve handling and one-cycle restore.
`include "mips_core.svh"
module reg_checkpoint_ctrl
  import ckpt_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int IDW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ckpt_req,
  output logic                   ckpt_ack,
  output logic [IDW-1:0]         ckpt_id,
  input  logic                   resolve_valid,
  input  logic                   resolve_mispredict,
  output logic                   resolve_err,
  write_back_ifc.in              i_wb,
  input  logic [`DATA_WIDTH-1:0] regs_in [NUM_REGS],
  output logic                   recover_snapshot,
  output logic [`DATA_WIDTH-1:0] regs_snapshot [NUM_REGS],
  output logic                   stall,
  output logic                   ckpt_full,
  output logic [IDW:0]           ckpt_count
);
  localparam int DW = `DATA_WIDTH;

  ckpt_state_t    state_reg;
  logic [IDW-1:0] head_reg, tail_reg;
  logic [IDW:0]   count_reg, count_next;
  logic           full_reg, err_reg, recover_reg;
  logic [DW-1:0]  snapshot_reg [NUM_REGS];
  logic [DW-1:0]  head_regs    [NUM_REGS];

  logic in_idle, has_ckpt, mispredict_in, correct_in;
  logic flush, retire, resolve_empty;

  always_comb begin
    in_idle       = (state_reg == IDLE);
    has_ckpt      = (count_reg != '0);
    mispredict_in = resolve_valid && resolve_mispredict;
    correct_in    = resolve_valid && !resolve_mispredict;
    // A correct resolve frees the oldest slot this cycle, so a full FIFO can still accept.
    ckpt_ack      = ckpt_req && in_idle && !mispredict_in &&
                    (count_reg < (IDW+1)'(DEPTH) || correct_in);
    flush         = in_idle && mispredict_in && has_ckpt;
    retire        = in_idle && correct_in && has_ckpt;
    resolve_empty = in_idle && resolve_valid && !has_ckpt;
    if (flush) begin
      count_next = '0;
    end else begin
      count_next = count_reg + (IDW+1)'(ckpt_ack) - (IDW+1)'(retire);
    end
  end

  reg_ckpt_store #(.DEPTH(DEPTH), .DW(DW), .IDW(IDW)) u_store (
    .clk     (clk),
    .wr_en   (ckpt_ack),
    .wr_idx  (tail_reg),
    .regs_in (regs_in),
    .wb_en   (i_wb.uses_rw),
    .wb_addr (i_wb.rw_addr),
    .wb_data (i_wb.rw_data),
    .rd_idx  (head_reg),
    .rd_regs (head_regs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      head_reg    <= '0;
      tail_reg    <= '0;
      count_reg   <= '0;
      full_reg    <= 1'b0;
      err_reg     <= 1'b0;
      recover_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        snapshot_reg[i] <= '0;
      end
    end else begin
      count_reg <= count_next;
      full_reg  <= (count_next == (IDW+1)'(DEPTH));
      if (resolve_empty) begin
        err_reg <= 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (flush) begin
            state_reg   <= RESTORE;
            recover_reg <= 1'b1;
            head_reg    <= '0;
            tail_reg    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
              snapshot_reg[i] <= head_regs[i];
            end
          end else begin
            head_reg <= head_reg + IDW'(retire);
            tail_reg <= tail_reg + IDW'(ckpt_ack);
          end
        end
        RESTORE: begin
          state_reg   <= IDLE;
          recover_reg <= 1'b0;
        end
        default: begin
          state_reg   <= IDLE;
          recover_reg <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_snap
    assign regs_snapshot[gi] = snapshot_reg[gi];
  end

  assign ckpt_id          = tail_reg;
  assign stall            = (state_reg == RESTORE) || flush;
  assign recover_snapshot = recover_reg;
  assign resolve_err      = err_reg;
  assign ckpt_full        = full_reg;
  assign ckpt_count       = count_reg;
endmodule

// File: tb/tb_reg_checkpoint_ctrl.sv
// Scoreboard bench for reg_checkpoint_ctrl: expected restore images are queued at mispredict.
module tb_reg_checkpoint_ctrl;
  localparam int DEPTH = 4;
  localparam int IDW   = 2;
  localparam int DW    = 32;
  typedef logic [31:0][DW-1:0] img_t;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ckpt_req, resolve_valid, resolve_mispredict;
  logic           ckpt_ack, resolve_err, recover_snapshot, stall, ckpt_full;
  logic [IDW-1:0] ckpt_id;
  logic [IDW:0]   ckpt_count;
  logic [DW-1:0]  regs_in       [32];
  logic [DW-1:0]  regs_snapshot [32];
  img_t           rf_p;

  write_back_ifc wb_if ();

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 32; i++) regs_in[i] = rf_p[i];
  end

  reg_checkpoint_ctrl #(.DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ckpt_req           (ckpt_req),
    .ckpt_ack           (ckpt_ack),
    .ckpt_id            (ckpt_id),
    .resolve_valid      (resolve_valid),
    .resolve_mispredict (resolve_mispredict),
    .resolve_err        (resolve_err),
    .i_wb               (wb_if),
    .regs_in            (regs_in),
    .recover_snapshot   (recover_snapshot),
    .regs_snapshot      (regs_snapshot),
    .stall              (stall),
    .ckpt_full          (ckpt_full),
    .ckpt_count         (ckpt_count)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  img_t ck_q  [$];
  img_t exp_q [$];
  int   m_tail       = 0;
  logic m_err        = 1'b0;
  logic m_restore    = 1'b0;
  int   strobes_exp  = 0;
  int   strobes_seen = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Restore strobe monitor: pops the image queued when the mispredict was driven.
  always @(negedge clk) begin
    if (rst_n && recover_snapshot) begin
      img_t e;
      int   bad;
      strobes_seen++;
      if (exp_q.size() == 0) begin
        check_value("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        e   = exp_q.pop_front();
        bad = 7;
        for (int k = 0; k < 32; k++) if (regs_snapshot[k] !== e[k]) bad = k;
        check_value($sformatf("snapshot_r%0d", bad), regs_snapshot[bad], e[bad]);
      end
    end
  end

  task automatic step(input logic req, input logic rv, input logic rm, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd, input logic exp_ack);
    logic mis, cor, restore_now;
    img_t img, restored;
    restore_now = m_restore;
    mis = !restore_now && rv && rm && (ck_q.size() > 0);
    cor = !restore_now && rv && !rm && (ck_q.size() > 0);
    ckpt_req = req; resolve_valid = rv; resolve_mispredict = rm;
    wb_if.uses_rw = we; wb_if.rw_addr = wa; wb_if.rw_data = wd;
    #1;
    check_value("ack", {31'd0, ckpt_ack}, {31'd0, exp_ack});
    if (exp_ack) check_value("id", {30'd0, ckpt_id}, m_tail);
    check_value("stall", {31'd0, stall}, {31'd0, restore_now || mis});
    img = rf_p;
    if (we && wa != 5'd0) img[wa] = wd;
    restored = img;
    @(posedge clk); #1;
    if (!restore_now && rv && ck_q.size() == 0) m_err = 1'b1;
    if (cor) void'(ck_q.pop_front());
    if (exp_ack) begin
      ck_q.push_back(img);
      m_tail = (m_tail + 1) % DEPTH;
    end
    if (mis) begin
      restored = ck_q[0];
      exp_q.push_back(restored);
      ck_q.delete();
      m_tail = 0;
      strobes_exp++;
    end
    rf_p      = restored;
    m_restore = mis;
    check_value("count", {29'd0, ckpt_count}, ck_q.size());
    check_value("full", {31'd0, ckpt_full}, {31'd0, ck_q.size() == DEPTH});
    check_value("err", {31'd0, resolve_err}, {31'd0, m_err});
    check_value("strobe", {31'd0, recover_snapshot}, {31'd0, mis});
    $display("[TB] req=%0b rv=%0b rm=%0b wb=%0b r%0d=0x%0h ack=%0b id=%0d count=%0d strobe=%0b",
             req, rv, rm, we, wa, wd, exp_ack, m_tail, ckpt_count, recover_snapshot);
    ckpt_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0; wb_if.uses_rw = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; ckpt_req = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    wb_if.uses_rw = 1'b0; wb_if.rw_addr = '0; wb_if.rw_data = '0;
    rf_p = '0;
    for (int i = 1; i < 32; i++) rf_p[i] = 32'h1000 + i;
    repeat (2) @(negedge clk);
    check_value("rst_count", {29'd0, ckpt_count}, 32'd0);
    check_value("rst_full", {31'd0, ckpt_full}, 32'd0);
    check_value("rst_err", {31'd0, resolve_err}, 32'd0);
    check_value("rst_strobe", {31'd0, recover_snapshot}, 32'd0);
    check_value("rst_stall", {31'd0, stall}, 32'd0);
    check_value("rst_snap_r7", regs_snapshot[7], 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // capture then correct resolve
    rf_p[5] = 32'h11;
    step(1, 0, 0, 0, 5'd0, 32'h0, 1);
    step(0, 1, 0, 0, 5'd0, 32'h0, 0);

    // write-back merge, mispredict, request during restore
    step(1, 0, 0, 1, 5'd7, 32'hAB, 1);
    step(0, 0, 0, 1, 5'd7, 32'hCD, 0);
    step(0, 1, 1, 0, 5'd0, 32'h0, 0);
    step(1, 0, 0, 0, 5'd0, 32'h0, 0);
    check_value("merge_r7", regs_snapshot[7], 32'hAB);
    check_value("merge_r5", regs_snapshot[5], 32'h11);

    // fill, reject when full, wrap with same-cycle retire
    for (int i = 0; i < DEPTH; i++) begin
      rf_p[1] = 32'h100 + i;
      step(1, 0, 0, 1, 5'd0, 32'hDEAD, 1);
    end
    step(1, 0, 0, 0, 5'd0, 32'h0, 0);
    rf_p[1] = 32'h1FF;
    step(1, 1, 0, 0, 5'd0, 32'h0, 1);

    // flush a full FIFO, then three checkpoints flushed from the oldest
    step(0, 1, 1, 0, 5'd0, 32'h0, 0);
    step(1, 0, 0, 0, 5'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      rf_p[2] = 32'h200 + i;
      step(1, 0, 0, 1, 5'd3, 32'h300 + i, 1);
    end
    step(0, 1, 1, 0, 5'd0, 32'h0, 0);
    step(0, 0, 0, 0, 5'd0, 32'h0, 0);
    check_value("flush_r2", regs_snapshot[2], 32'h200);

    // resolve with nothing outstanding
    step(0, 1, 0, 0, 5'd0, 32'h0, 0);
    step(0, 1, 1, 0, 5'd0, 32'h0, 0);
    step(1, 0, 0, 0, 5'd0, 32'h0, 1);
    step(0, 1, 0, 0, 5'd0, 32'h0, 0);

    // reset asserted during restore
    step(1, 0, 0, 0, 5'd0, 32'h0, 1);
    resolve_valid = 1'b1; resolve_mispredict = 1'b1;
    #1;
    check_value("mis_stall", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    check_value("mis_strobe", {31'd0, recover_snapshot}, 32'd1);
    resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    rst_n = 1'b0;
    #1;
    check_value("abort_strobe", {31'd0, recover_snapshot}, 32'd0);
    check_value("abort_stall", {31'd0, stall}, 32'd0);
    check_value("abort_count", {29'd0, ckpt_count}, 32'd0);
    check_value("abort_err", {31'd0, resolve_err}, 32'd0);
    ck_q.delete(); m_tail = 0; m_err = 1'b0; m_restore = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 0, 0, 0, 5'd0, 32'h0, 1);

    check_value("strobe_total", strobes_seen, strobes_exp);
    check_value("exp_q_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
